// File: rtl/pe_array_feeder_if.sv
// Bundle of the job-control, operand-input and array-edge signals of the
// systolic-array left-edge feeder. The master side is whoever issues jobs and
// supplies vectors. The slave side is the feeder itself.
interface pe_array_feeder_if #(
    parameter int DATA_W = 16,
    parameter int ROWS   = 4,
    parameter int LEN_W  = 8
);
    logic                   start;
    logic [LEN_W-1:0]       len;
    logic                   in_valid;
    logic                   in_ready;
    logic [ROWS*DATA_W-1:0] in_data;
    logic [ROWS*DATA_W-1:0] edge_data;
    logic [ROWS-1:0]        edge_valid;
    logic                   busy;
    logic                   done;

    modport master (
        output start, len, in_valid, in_data,
        input  in_ready, edge_data, edge_valid, busy, done
    );

    modport slave (
        input  start, len, in_valid, in_data,
        output in_ready, edge_data, edge_valid, busy, done
    );
endinterface

// File: rtl/pe_array_feeder.sv
// Left-edge sequencer for a ROWS x COLS systolic array of registered PEs.
// It accepts a job of len vectors through valid/ready and skews each vector so
// that row r sees its element r cycles after row 0. It then idles the edge with
// zeros for ROWS+COLS-1 cycles, so the last wavefront clears the array, and
// pulses done.
module pe_array_feeder #(
    parameter int DATA_W = 16,
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int LEN_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    pe_array_feeder_if.slave   bus
);
    // Drain length: a wavefront needs ROWS-1 extra cycles of skew plus COLS
    // hops to leave the bottom-right PE.
    localparam int D       = ROWS + COLS - 1;
    localparam int DRAIN_W = $clog2(D + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [LEN_W-1:0]     acc_cnt_q, acc_cnt_d;
    logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic [LEN_W-1:0]     acc_inc;
    logic                 accept;

    // Handshake and status decode straight from the state register.
    assign bus.in_ready = (state_q == FEED);
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
    assign accept       = bus.in_valid & bus.in_ready;
    assign acc_inc      = acc_cnt_q + LEN_W'(1);

    // Next-state and counter logic for the IDLE->FEED->DRAIN->DONE job sequence.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves one unassigned, which would infer a latch.
        state_d     = state_q;
        len_d       = len_q;
        acc_cnt_d   = acc_cnt_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.len != '0) begin
                        state_d   = FEED;
                        len_d     = bus.len;
                        acc_cnt_d = '0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            FEED: begin
                if (accept) begin
                    acc_cnt_d = acc_inc;
                    if (acc_inc == len_q) begin
                        state_d     = DRAIN;
                        drain_cnt_d = '0;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DRAIN_W'(D - 1)) begin
                    state_d = DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers: state, latched job length and the two counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            len_q       <= '0;
            acc_cnt_q   <= '0;
            drain_cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples its pre-edge inputs regardless of statement order.
            state_q     <= state_d;
            len_q       <= len_d;
            acc_cnt_q   <= acc_cnt_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // One skew shift register per row: row r is r+1 stages deep. A stage
    // carries data and valid together, and data is zero whenever valid is zero.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [r:0][DATA_W-1:0] data_q, data_d;
        logic [r:0]             valid_q, valid_d;

        // Inject this row's element on an accept, or a zero bubble otherwise. Shift the rest.
        always_comb begin
            data_d[0]  = accept ? bus.in_data[r*DATA_W +: DATA_W] : '0;
            valid_d[0] = accept;
            for (int k = 1; k <= r; k++) begin
                data_d[k]  = data_q[k-1];
                valid_d[k] = valid_q[k-1];
            end
        end

        // Skew stages for this row.
        always_ff @(posedge clk or posedge reset) begin
            // NOTE: these datapath stages are reset on purpose. A mid-job reset
            // must not leave stale operands or valids in flight toward the array.
            if (reset) begin
                data_q  <= '0;
                valid_q <= '0;
            end else begin
                data_q  <= data_d;
                valid_q <= valid_d;
            end
        end

        assign bus.edge_data[r*DATA_W +: DATA_W] = data_q[r];
        assign bus.edge_valid[r]                 = valid_q[r];
    end

endmodule

// File: tb/tb_pe_array_feeder.sv
// Directed bench for pe_array_feeder (ROWS=4, COLS=4, DATA_W=16, drain of 7).
// It applies a table of per-cycle {inputs, expected outputs} records, followed by
// short hand-written sequences around asynchronous reset.
module tb_pe_array_feeder;
    localparam int DATA_W = 16;
    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int LEN_W  = 8;

    typedef struct packed {
        logic        in_ready;
        logic [3:0]  edge_valid;
        logic [63:0] edge_data;
        logic        busy;
        logic        done;
    } out_t;

    typedef struct packed {
        logic        start;
        logic [7:0]  len;
        logic        in_valid;
        logic [63:0] in_data;
        out_t        exp;
    } vec_t;

    logic clk;
    logic reset;
    vec_t vecs[$];
    int   n_vec;
    int   n_err;
    int   vec_id;

    pe_array_feeder_if #(.DATA_W(DATA_W), .ROWS(ROWS), .LEN_W(LEN_W)) bus ();

    pe_array_feeder #(
        .DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS), .LEN_W(LEN_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ed4(input logic [15:0] e3, e2, e1, e0);
        return {e3, e2, e1, e0};
    endfunction

    function automatic logic [63:0] ed_only(input int r, input logic [63:0] din);
        logic [63:0] m;
        m = '0;
        m[r*16 +: 16] = din[r*16 +: 16];
        return m;
    endfunction

    function automatic out_t mk_out(input logic rdy, input logic [3:0] ev,
                                    input logic [63:0] ed, input logic bsy, input logic dn);
        out_t o;
        o.in_ready   = rdy;
        o.edge_valid = ev;
        o.edge_data  = ed;
        o.busy       = bsy;
        o.done       = dn;
        return o;
    endfunction

    function automatic out_t sample();
        return mk_out(bus.in_ready, bus.edge_valid, bus.edge_data, bus.busy, bus.done);
    endfunction

    task automatic check(input string name, input out_t got, input out_t exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got rdy=%b ev=%b ed=%h busy=%b done=%b, want rdy=%b ev=%b ed=%h busy=%b done=%b",
                     name, got.in_ready, got.edge_valid, got.edge_data, got.busy, got.done,
                     exp.in_ready, exp.edge_valid, exp.edge_data, exp.busy, exp.done);
        end
    endtask

    task automatic drive(input logic st, input logic [7:0] ln, input logic iv,
                         input logic [63:0] din);
        bus.start    = st;
        bus.len      = ln;
        bus.in_valid = iv;
        bus.in_data  = din;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic st, input logic [7:0] ln, input logic iv, input logic [63:0] din,
                       input logic rdy, input logic [3:0] ev, input logic [63:0] ed,
                       input logic bsy, input logic dn);
        vec_t v;
        v.start    = st;
        v.len      = ln;
        v.in_valid = iv;
        v.in_data  = din;
        v.exp      = mk_out(rdy, ev, ed, bsy, dn);
        vecs.push_back(v);
    endtask

    // Three quiet drain cycles, the done cycle, then the first idle cycle.
    task automatic add_tail(input logic iv, input logic [63:0] din);
        for (int i = 0; i < 3; i++) add(0, 0, iv, din, 0, 4'b0000, 64'h0, 1, 0);
        add(0, 0, iv, din, 0, 4'b0000, 64'h0, 1, 1);
        add(0, 0, iv, din, 0, 4'b0000, 64'h0, 0, 0);
    endtask

    // Single-vector job. With hold set, in_valid stays high with junk data in
    // every cycle except the accepting one.
    task automatic add_len1_job(input logic [63:0] din, input logic hold, input logic [63:0] junk);
        add(1, 1, hold, junk, 0, 4'b0000, 64'h0, 0, 0);
        add(0, 0, 1, din, 1, 4'b0000, 64'h0, 1, 0);
        for (int r = 0; r < 4; r++)
            add(0, 0, hold, junk, 0, 4'(1 << r), ed_only(r, din), 1, 0);
        add_tail(hold, junk);
    endtask

    // Drive each record, compare at the falling edge, and clock it in.
    task automatic run_table();
        foreach (vecs[i]) begin
            drive(vecs[i].start, vecs[i].len, vecs[i].in_valid, vecs[i].in_data);
            @(negedge clk);
            check($sformatf("vec%0d", vec_id), sample(), vecs[i].exp);
            vec_id++;
            @(posedge clk);
            #1;
        end
        vecs.delete();
        drive(0, 0, 0, 64'h0);
    endtask

    initial begin : main
        logic [63:0] va, vb, vc, vd, ve, vf, vg, v1, v2, vn;
        out_t zero;
        n_vec  = 0;
        n_err  = 0;
        vec_id = 0;
        zero   = mk_out(0, 4'b0000, 64'h0, 0, 0);
        va = ed4(16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0);
        vb = ed4(16'h00B3, 16'h00B2, 16'h00B1, 16'h00B0);
        vc = ed4(16'h00C3, 16'h00C2, 16'h00C1, 16'h00C0);
        vd = ed4(16'h00D3, 16'h00D2, 16'h00D1, 16'h00D0);
        ve = ed4(16'h00E3, 16'h00E2, 16'h00E1, 16'h00E0);
        vf = ed4(16'h0F03, 16'h0F02, 16'h0F01, 16'h0F00);
        vg = 64'hDEAD_BEEF_CAFE_F00D;
        v1 = ed4(16'h1113, 16'h1112, 16'h1111, 16'h1110);
        v2 = ed4(16'h2223, 16'h2222, 16'h2221, 16'h2220);
        vn = ed4(16'h8004, 16'h8003, 16'h8002, 16'h8001);

        reset = 1'b1;
        drive(0, 0, 0, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // ---- table: idle, single vector, gapped job, zero-length job, stray valids
        add(0, 0, 0, 64'h0, 0, 4'b0000, 64'h0, 0, 0);
        add(0, 0, 0, 64'h0, 0, 4'b0000, 64'h0, 0, 0);

        add_len1_job(ed4(16'd4, 16'd3, 16'd2, 16'd1), 1'b0, 64'h0);

        add(1, 3, 0, 64'h0, 0, 4'b0000, 64'h0, 0, 0);
        add(0, 0, 1, va,    1, 4'b0000, 64'h0, 1, 0);
        add(0, 0, 0, 64'h0, 1, 4'b0001, ed4(0, 0, 0, 16'h00A0), 1, 0);
        add(0, 0, 0, 64'h0, 1, 4'b0010, ed4(0, 0, 16'h00A1, 0), 1, 0);
        add(0, 0, 1, vb,    1, 4'b0100, ed4(0, 16'h00A2, 0, 0), 1, 0);
        add(0, 0, 1, vc,    1, 4'b1001, ed4(16'h00A3, 0, 0, 16'h00B0), 1, 0);
        add(0, 0, 0, 64'h0, 0, 4'b0011, ed4(0, 0, 16'h00B1, 16'h00C0), 1, 0);
        add(0, 0, 0, 64'h0, 0, 4'b0110, ed4(0, 16'h00B2, 16'h00C1, 0), 1, 0);
        add(0, 0, 0, 64'h0, 0, 4'b1100, ed4(16'h00B3, 16'h00C2, 0, 0), 1, 0);
        add(0, 0, 0, 64'h0, 0, 4'b1000, ed4(16'h00C3, 0, 0, 0), 1, 0);
        add_tail(0, 64'h0);

        add(1, 0, 0, 64'h0, 0, 4'b0000, 64'h0, 0, 0);
        add(0, 0, 0, 64'h0, 0, 4'b0000, 64'h0, 1, 1);
        add(1, 2, 0, 64'h0, 0, 4'b0000, 64'h0, 0, 0);
        add(1, 5, 0, 64'h0, 1, 4'b0000, 64'h0, 1, 0);
        add(0, 0, 1, vd,    1, 4'b0000, 64'h0, 1, 0);
        add(0, 0, 1, ve,    1, 4'b0001, ed4(0, 0, 0, 16'h00D0), 1, 0);
        add(0, 0, 0, 64'h0, 0, 4'b0011, ed4(0, 0, 16'h00D1, 16'h00E0), 1, 0);
        add(0, 0, 0, 64'h0, 0, 4'b0110, ed4(0, 16'h00D2, 16'h00E1, 0), 1, 0);
        add(0, 0, 0, 64'h0, 0, 4'b1100, ed4(16'h00D3, 16'h00E2, 0, 0), 1, 0);
        add(0, 0, 0, 64'h0, 0, 4'b1000, ed4(16'h00E3, 0, 0, 0), 1, 0);
        add_tail(0, 64'h0);

        add_len1_job(vf, 1'b1, vg);
        add(0, 0, 1, vg, 0, 4'b0000, 64'h0, 0, 0);
        add(0, 0, 1, vg, 0, 4'b0000, 64'h0, 0, 0);
        add_len1_job(ed4(16'h0055, 16'h0044, 16'h0033, 16'h0022), 1'b0, 64'h0);
        run_table();

        // ---- async reset while idle
        #2;
        reset = 1'b1;
        #1;
        check("reset_idle", sample(), zero);
        tick();
        reset = 1'b0;

        // ---- async reset while a valid sits on row 0 during drain
        drive(1, 1, 0, 64'h0);
        tick();
        drive(0, 0, 1, v1);
        tick();
        drive(0, 0, 0, 64'h0);
        check("drain_before_reset", sample(), mk_out(0, 4'b0001, ed_only(0, v1), 1, 0));
        #2;
        reset = 1'b1;
        #1;
        check("reset_in_drain", sample(), zero);
        tick();
        reset = 1'b0;
        check("after_drain_reset", sample(), zero);

        // ---- reset in FEED after 2 of 4 accepts, then a fresh single-vector job
        drive(1, 4, 0, 64'h0);
        tick();
        drive(0, 0, 1, v1);
        tick();
        drive(0, 0, 1, v2);
        tick();
        drive(0, 0, 0, 64'h0);
        check("feed_before_reset", sample(),
              mk_out(1, 4'b0011, ed4(0, 0, 16'h1111, 16'h2220), 1, 0));
        #2;
        reset = 1'b1;
        #1;
        check("reset_in_feed", sample(), zero);
        tick();
        reset = 1'b0;
        add_len1_job(vn, 1'b0, 64'h0);
        run_table();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
